pc_return_stack: RTL and testbench

//  Call/return address LIFO that drives the load side of the 5-bit program counter register.
//  - On CALL: pushes the return address (pc_in+1) and commands a PC load of the call target.
//  - On RET: pops the most recent return address and commands a PC load of it.
//  - Sits between the control decoder and the PC register.
//  - load_out/load_addr connect directly to the PC register's load/in pins.

---
 rtl/pc_return_stack.sv | 103 ++++++++++
 tb/tb_pc_return_stack.sv | 139 +++++++++++++
 2 files changed

// File: rtl/pc_return_stack.sv
// Call/return address LIFO feeding the PC register's load port.
// Pushes pc_in+1 on call, pops on ret, and keeps sticky error flags for misuse.
module pc_return_stack #(
  parameter int AW    = 5,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic [AW-1:0] pc_in,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] target,
  input  logic          clr_err,
  output logic          load_out,
  output logic [AW-1:0] load_addr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic          underflow,
  output logic          proto_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] stack_q [DEPTH];
  logic [AW-1:0] stack_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] load_addr_q, load_addr_d;
  logic          load_out_q, load_out_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          proto_err_q, proto_err_d;
  logic [CW-1:0] top_idx;
  logic          full_w, empty_w;

  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);
  assign top_idx = count_q - CW'(1);

  always_comb begin
    stack_d     = stack_q;
    count_d     = count_q;
    load_addr_d = load_addr_q;
    load_out_d  = 1'b0;
    // Clear is applied first so an error detected in the same cycle wins.
    overflow_d  = clr_err ? 1'b0 : overflow_q;
    underflow_d = clr_err ? 1'b0 : underflow_q;
    proto_err_d = clr_err ? 1'b0 : proto_err_q;

    if (call && ret) begin
      proto_err_d = 1'b1;
    end else if (call) begin
      if (full_w) begin
        overflow_d = 1'b1;
      end else begin
        stack_d[count_q[IW-1:0]] = pc_in + AW'(1);
        count_d     = count_q + CW'(1);
        load_addr_d = target;
        load_out_d  = 1'b1;
      end
    end else if (ret) begin
      if (empty_w) begin
        underflow_d = 1'b1;
      end else begin
        load_addr_d = stack_q[top_idx[IW-1:0]];
        count_d     = top_idx;
        load_out_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      count_q     <= '0;
      load_addr_q <= '0;
      load_out_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      stack_q     <= stack_d;
      count_q     <= count_d;
      load_addr_q <= load_addr_d;
      load_out_q  <= load_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign load_out  = load_out_q;
  assign load_addr = load_addr_q;
  assign count     = count_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_pc_return_stack.sv
// Scoreboard bench for pc_return_stack: directed vectors push hand-computed
// expectations, a negedge monitor pops and compares them against the outputs.
module tb_pc_return_stack;

  typedef struct {
    string      name;
    logic       load;
    logic [4:0] addr;
    logic [2:0] cnt;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
    logic       perr;
  } exp_t;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic [4:0] pc_in = '0;
  logic       call = 1'b0;
  logic       ret = 1'b0;
  logic [4:0] target = '0;
  logic       clr_err = 1'b0;
  logic       load_out;
  logic [4:0] load_addr;
  logic [2:0] count;
  logic       full, empty, overflow, underflow, proto_err;

  exp_t exp_q[$];
  int   vec_count  = 0;
  int   miss_count = 0;

  pc_return_stack #(.AW(5), .DEPTH(4), .CW(3)) dut (
    .clk(clk), .res_n(res_n), .pc_in(pc_in), .call(call), .ret(ret),
    .target(target), .clr_err(clr_err), .load_out(load_out),
    .load_addr(load_addr), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  function automatic exp_t make_exp(string name, logic load, logic [4:0] addr,
                                    logic [2:0] cnt, logic ovf, logic unf, logic perr);
    exp_t e;
    e.name = name; e.load = load; e.addr = addr; e.cnt = cnt;
    e.full = (cnt == 3'd4); e.empty = (cnt == 3'd0);
    e.ovf = ovf; e.unf = unf; e.perr = perr;
    return e;
  endfunction

  task automatic checkOutput(input exp_t e);
    vec_count++;
    if (load_out !== e.load || load_addr !== e.addr || count !== e.cnt ||
        full !== e.full || empty !== e.empty || overflow !== e.ovf ||
        underflow !== e.unf || proto_err !== e.perr) begin
      miss_count++;
      $display("[TB] FAIL %s: got load=%0b addr=%0d cnt=%0d full=%0b empty=%0b ovf=%0b unf=%0b perr=%0b, expected load=%0b addr=%0d cnt=%0d full=%0b empty=%0b ovf=%0b unf=%0b perr=%0b",
               e.name, load_out, load_addr, count, full, empty, overflow, underflow, proto_err,
               e.load, e.addr, e.cnt, e.full, e.empty, e.ovf, e.unf, e.perr);
    end
  endtask

  // Drive one request, let it be sampled, then queue the expected outputs.
  task automatic applyStimulus(input string name, input logic c, input logic r,
                               input logic [4:0] pc, input logic [4:0] tgt, input logic clr,
                               input logic load, input logic [4:0] addr, input logic [2:0] cnt,
                               input logic ovf, input logic unf, input logic perr);
    call = c; ret = r; pc_in = pc; target = tgt; clr_err = clr;
    @(posedge clk);
    exp_q.push_back(make_exp(name, load, addr, cnt, ovf, unf, perr));
    #1;
    call = 1'b0; ret = 1'b0; clr_err = 1'b0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2;
    checkOutput(make_exp("reset_initial", 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0));
    #1 res_n = 1'b1;

    //              name          call ret  pc     tgt    clr   load addr   cnt  ovf  unf  perr
    applyStimulus("idle0",       1'b0,1'b0,5'd0, 5'd0, 1'b0, 1'b0,5'd0, 3'd0,1'b0,1'b0,1'b0);
    applyStimulus("call_a",      1'b1,1'b0,5'd3, 5'd10,1'b0, 1'b1,5'd10,3'd1,1'b0,1'b0,1'b0);
    applyStimulus("call_b",      1'b1,1'b0,5'd10,5'd20,1'b0, 1'b1,5'd20,3'd2,1'b0,1'b0,1'b0);
    applyStimulus("ret_b",       1'b0,1'b1,5'd20,5'd0, 1'b0, 1'b1,5'd11,3'd1,1'b0,1'b0,1'b0);
    applyStimulus("ret_a",       1'b0,1'b1,5'd11,5'd0, 1'b0, 1'b1,5'd4, 3'd0,1'b0,1'b0,1'b0);
    applyStimulus("idle_hold",   1'b0,1'b0,5'd4, 5'd0, 1'b0, 1'b0,5'd4, 3'd0,1'b0,1'b0,1'b0);
    // pc_in=31 wraps so the pushed return address is 0.
    applyStimulus("call_wrap",   1'b1,1'b0,5'd31,5'd9, 1'b0, 1'b1,5'd9, 3'd1,1'b0,1'b0,1'b0);
    applyStimulus("ret_wrap",    1'b0,1'b1,5'd9, 5'd0, 1'b0, 1'b1,5'd0, 3'd0,1'b0,1'b0,1'b0);
    applyStimulus("call_f1",     1'b1,1'b0,5'd1, 5'd16,1'b0, 1'b1,5'd16,3'd1,1'b0,1'b0,1'b0);
    applyStimulus("call_f2",     1'b1,1'b0,5'd2, 5'd17,1'b0, 1'b1,5'd17,3'd2,1'b0,1'b0,1'b0);
    applyStimulus("call_f3",     1'b1,1'b0,5'd3, 5'd18,1'b0, 1'b1,5'd18,3'd3,1'b0,1'b0,1'b0);
    applyStimulus("call_f4",     1'b1,1'b0,5'd4, 5'd19,1'b0, 1'b1,5'd19,3'd4,1'b0,1'b0,1'b0);
    applyStimulus("call_ovf",    1'b1,1'b0,5'd5, 5'd20,1'b0, 1'b0,5'd19,3'd4,1'b1,1'b0,1'b0);
    applyStimulus("ret_f4",      1'b0,1'b1,5'd0, 5'd0, 1'b0, 1'b1,5'd5, 3'd3,1'b1,1'b0,1'b0);
    applyStimulus("ret_f3",      1'b0,1'b1,5'd0, 5'd0, 1'b0, 1'b1,5'd4, 3'd2,1'b1,1'b0,1'b0);
    applyStimulus("ret_f2",      1'b0,1'b1,5'd0, 5'd0, 1'b0, 1'b1,5'd3, 3'd1,1'b1,1'b0,1'b0);
    applyStimulus("ret_f1",      1'b0,1'b1,5'd0, 5'd0, 1'b0, 1'b1,5'd2, 3'd0,1'b1,1'b0,1'b0);
    applyStimulus("ret_unf",     1'b0,1'b1,5'd0, 5'd0, 1'b0, 1'b0,5'd2, 3'd0,1'b1,1'b1,1'b0);
    applyStimulus("proto_empty", 1'b1,1'b1,5'd0, 5'd0, 1'b0, 1'b0,5'd2, 3'd0,1'b1,1'b1,1'b1);
    applyStimulus("clr_all",     1'b0,1'b0,5'd0, 5'd0, 1'b1, 1'b0,5'd2, 3'd0,1'b0,1'b0,1'b0);
    applyStimulus("clr_set_unf", 1'b0,1'b1,5'd0, 5'd0, 1'b1, 1'b0,5'd2, 3'd0,1'b0,1'b1,1'b0);
    applyStimulus("clr_again",   1'b0,1'b0,5'd0, 5'd0, 1'b1, 1'b0,5'd2, 3'd0,1'b0,1'b0,1'b0);
    applyStimulus("call_p",      1'b1,1'b0,5'd8, 5'd12,1'b0, 1'b1,5'd12,3'd1,1'b0,1'b0,1'b0);
    applyStimulus("proto_full",  1'b1,1'b1,5'd8, 5'd25,1'b0, 1'b0,5'd12,3'd1,1'b0,1'b0,1'b1);
    applyStimulus("ret_p_clr",   1'b0,1'b1,5'd0, 5'd0, 1'b1, 1'b1,5'd9, 3'd0,1'b0,1'b0,1'b0);
    applyStimulus("call_q",      1'b1,1'b0,5'd14,5'd21,1'b0, 1'b1,5'd21,3'd1,1'b0,1'b0,1'b0);

    // Mid-cycle reset with a call pending: outputs clear at once, call is discarded.
    call = 1'b1; pc_in = 5'd5; target = 5'd6;
    @(negedge clk);
    #1 res_n = 1'b0; call = 1'b0;
    #1 checkOutput(make_exp("reset_mid", 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0));
    #1 res_n = 1'b1;
    applyStimulus("post_reset",  1'b0,1'b0,5'd0, 5'd0, 1'b0, 1'b0,5'd0, 3'd0,1'b0,1'b0,1'b0);
    applyStimulus("ret_post",    1'b0,1'b1,5'd0, 5'd0, 1'b0, 1'b0,5'd0, 3'd0,1'b0,1'b1,1'b0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      vec_count++;
      miss_count++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
